// File: rtl/cpu_trace_pkg.sv
// ----------------------------------------------------------------------------
// cpu_trace_pkg
//   Shared definitions for the CPU run controller / write-back trace recorder.
//   - FSM state encoding
//   - trace entry width and field offsets inside rd_data_o
//     entry layout (MSB..LSB): {cycle[CYC_W], pc[PC_W], rd[5], data[XLEN]}
// ----------------------------------------------------------------------------
package cpu_trace_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int RD_W = 5;

    function automatic int ent_w(input int cyc_w, input int pc_w, input int xlen);
        return cyc_w + pc_w + RD_W + xlen;
    endfunction

    // LSB position of each field within an entry
    function automatic int off_data();
        return 0;
    endfunction

    function automatic int off_rd(input int xlen);
        return xlen;
    endfunction

    function automatic int off_pc(input int xlen);
        return xlen + RD_W;
    endfunction

    function automatic int off_cyc(input int xlen, input int pc_w);
        return xlen + RD_W + pc_w;
    endfunction

endpackage

// File: rtl/cpu_trace_monitor_fifo.sv
// ----------------------------------------------------------------------------
// trace_fifo
//   First-word fall-through FIFO holding trace entries.
//   Ports:
//     clk_i, rst_i  clock, async active-low reset (pointers only)
//     push, wdata   write request; ignored when full unless popping too
//     pop           read request; ignored when empty
//     rdata         head entry (0 while empty)
//     full, empty   status
//   Pointers carry one extra wrap bit so full/empty are distinguishable.
// ----------------------------------------------------------------------------
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_do_push = push & (~full | w_do_pop);

    // masked head keeps rd_data_o at 0 while nothing is valid
    assign rdata = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// ----------------------------------------------------------------------------
// cpu_trace_monitor
//   Run controller and write-back trace recorder for the CPU.
//   A start rising edge arms a run; the run stops after MAX_CYCLES cycles or
//   when the PC hits halt_pc_i. Every non-x0 register write during the run is
//   stored as {cycle, pc, rd, data} in a FIFO drained through rd_valid/ready.
//   Ports:
//     clk_i, rst_i               clock, async active-low reset
//     start_i                    level, rising edge starts a run (IDLE/DONE)
//     pc_i                       current CPU PC
//     rf_we_i/rf_waddr_i/rf_wdata_i  register-file write-back
//     halt_en_i, halt_pc_i       PC-match stop
//     rd_ready_i, rd_valid_o, rd_data_o  trace drain port
//     running_o, done_o          registered FSM decodes
//     cycle_cnt_o                cycles elapsed in current run
//     overflow_o, drop_cnt_o     dropped-entry status for current run
// ----------------------------------------------------------------------------
module cpu_trace_monitor
    import cpu_trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int CYC_W      = 16,
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 30,
    localparam int ENT_W     = ent_w(CYC_W, PC_W, XLEN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             rf_we_i,
    input  logic [4:0]       rf_waddr_i,
    input  logic [XLEN-1:0]  rf_wdata_i,
    input  logic             halt_en_i,
    input  logic [PC_W-1:0]  halt_pc_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [ENT_W-1:0] rd_data_o,
    output logic             running_o,
    output logic             done_o,
    output logic [CYC_W-1:0] cycle_cnt_o,
    output logic             overflow_o,
    output logic [CYC_W-1:0] drop_cnt_o
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_start_q;
    logic             r_running;
    logic             r_done;
    logic [CYC_W-1:0] r_cnt;
    logic             r_ovf;
    logic [CYC_W-1:0] r_drop;

    logic             w_start_rise;
    logic             w_stop;
    logic             w_enter_run;
    logic             w_in_run;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [ENT_W-1:0] w_entry;
    logic [ENT_W-1:0] w_rdata;

    assign w_start_rise = start_i & ~r_start_q;
    assign w_in_run     = (r_state == ST_RUN);
    assign w_stop       = (r_cnt == CYC_W'(MAX_CYCLES - 1)) |
                          (halt_en_i & (pc_i == halt_pc_i));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_rise) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_stop)       w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty)      w_state_nxt = ST_DONE;
            ST_DONE:  if (w_start_rise) w_state_nxt = ST_RUN;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_run = (w_state_nxt == ST_RUN) & ~w_in_run;

    // capture qualification: only architectural writes during the run
    assign w_push  = w_in_run & rf_we_i & (rf_waddr_i != 5'd0);
    assign w_pop   = ~w_empty & rd_ready_i;
    assign w_drop  = w_push & w_full & ~w_pop;
    assign w_entry = {r_cnt, pc_i, rf_waddr_i, rf_wdata_i};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start_i;
            // decode the next state so the flags line up with r_state
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    // the stop cycle keeps its own timestamp, so the count freezes there
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (w_enter_run) begin
            r_cnt <= '0;
        end else if (w_in_run && !w_stop) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_enter_run) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != '1) r_drop <= r_drop + 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_entry),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rd_valid_o  = ~w_empty;
    assign rd_data_o   = w_rdata;
    assign running_o   = r_running;
    assign done_o      = r_done;
    assign cycle_cnt_o = r_cnt;
    assign overflow_o  = r_ovf;
    assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// ----------------------------------------------------------------------------
// tb_cpu_trace_monitor
//   Scoreboard bench. The driver walks each run cycle by cycle, decides from
//   the run rules which writes are kept or dropped (FIFO modelled as an
//   occupancy count plus an expected-entry queue), and a separate monitor
//   compares every entry the DUT hands out against the queue head.
// ----------------------------------------------------------------------------
module tb_cpu_trace_monitor;

    localparam int XLEN  = 32;
    localparam int PC_W  = 32;
    localparam int CYC_W = 16;
    localparam int DEPTH = 4;
    localparam int MAXC  = 30;
    localparam int ENT_W = CYC_W + PC_W + 5 + XLEN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [PC_W-1:0]  pc = '0;
    logic             we = 1'b0;
    logic [4:0]       waddr = '0;
    logic [XLEN-1:0]  wdata = '0;
    logic             halt_en = 1'b0;
    logic [PC_W-1:0]  halt_pc = '0;
    logic             rdy = 1'b0;
    logic             rd_valid;
    logic [ENT_W-1:0] rd_data;
    logic             running;
    logic             done;
    logic [CYC_W-1:0] cyc_cnt;
    logic             ovf;
    logic [CYC_W-1:0] drop_cnt;

    cpu_trace_monitor #(
        .XLEN(XLEN), .PC_W(PC_W), .CYC_W(CYC_W), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .pc_i       (pc),
        .rf_we_i    (we),
        .rf_waddr_i (waddr),
        .rf_wdata_i (wdata),
        .halt_en_i  (halt_en),
        .halt_pc_i  (halt_pc),
        .rd_ready_i (rdy),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .running_o  (running),
        .done_o     (done),
        .cycle_cnt_o(cyc_cnt),
        .overflow_o (ovf),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ENT_W-1:0] sb_q[$];
    int m_occ   = 0;
    int m_drops = 0;
    int stop_k  = 0;

    logic            st_we   [MAXC];
    logic [4:0]      st_addr [MAXC];
    logic [XLEN-1:0] st_data [MAXC];
    logic            st_rdy  [MAXC];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // monitor: every accepted handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && rd_valid && rdy) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL trace_pop: got %0h, expected no entry", rd_data);
            end else begin
                chk("trace_entry", rd_data, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: one cycle of the FIFO / capture rules, from the driven inputs
    task automatic model_step(input bit in_run, input int k);
        bit pop_now;
        bit acc;
        pop_now = (m_occ > 0) && rdy;
        acc     = 1'b0;
        if (in_run && we && waddr != 5'd0) begin
            if (m_occ < DEPTH || pop_now) begin
                sb_q.push_back({CYC_W'(k), pc, waddr, wdata});
                acc = 1'b1;
            end else begin
                m_drops++;
            end
        end
        m_occ = m_occ - int'(pop_now) + int'(acc);
    endtask

    task automatic clr_stim();
        for (int k = 0; k < MAXC; k++) begin
            st_we[k] = 1'b0; st_addr[k] = '0; st_data[k] = '0; st_rdy[k] = 1'b1;
        end
    endtask

    task automatic rnd_stim();
        for (int k = 0; k < MAXC; k++) begin
            st_we[k]   = ($urandom_range(0, 9) < 6);
            st_addr[k] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            st_data[k] = $urandom;
            st_rdy[k]  = $urandom_range(0, 1);
        end
    endtask

    // IDLE/DONE cycles: a write is offered but must not be captured
    task automatic start_pulse();
        start = 1'b0; we = 1'b1; waddr = 5'd7; wdata = $urandom;
        model_step(1'b0, 0);
        tick();
        start = 1'b1;
        model_step(1'b0, 0);
        tick();
    endtask

    task automatic do_run(input bit hen, input logic [PC_W-1:0] hpc, input int hold);
        bit stop;
        bit last;
        int i;
        m_drops = 0;
        halt_en = hen;
        halt_pc = hpc;
        for (int k = 0; k < MAXC; k++) begin
            pc = PC_W'(4 * k);
            we = st_we[k]; waddr = st_addr[k]; wdata = st_data[k]; rdy = st_rdy[k];
            start = $urandom_range(0, 1);
            stop  = (k == MAXC - 1) || (hen && pc == hpc);
            model_step(1'b1, k);
            @(negedge clk);
            chk("run_running", running, 1);
            chk("run_cycle_cnt", cyc_cnt, k);
            if (k == 0) begin
                chk("run_ovf_clear", ovf, 0);
                chk("run_drop_clear", drop_cnt, 0);
            end
            tick();
            if (stop) begin
                stop_k = k;
                break;
            end
        end
        i = 0;
        do begin
            last  = (m_occ == 0);
            we    = $urandom_range(0, 1); waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
            start = 1'b1;
            rdy   = (i < hold) ? 1'b0 : 1'b1;
            model_step(1'b0, 0);
            @(negedge clk);
            chk("drain_running", running, 0);
            chk("drain_done", done, 0);
            tick();
            i++;
            if (i > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_timeout: got %0d cycles, expected <= 200", i);
                break;
            end
        end while (!last);
        we = 1'b0;
        model_step(1'b0, 0);
        @(negedge clk);
        chk("done_flag", done, 1);
        chk("done_running", running, 0);
        chk("done_cycle_cnt", cyc_cnt, stop_k);
        chk("done_overflow", ovf, (m_drops > 0));
        chk("done_drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
        chk("done_rd_valid", rd_valid, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cyc_cnt, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drop", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // async reset in the middle of a run discards the buffered entries
        start_pulse();
        for (int k = 0; k < 4; k++) begin
            pc = PC_W'(4 * k); we = 1'b1; waddr = 5'(k + 1); wdata = $urandom; rdy = 1'b0;
            if (k < 3) begin
                model_step(1'b1, k);
                tick();
            end
        end
        #1 rst_n = 1'b0;
        #1;
        chk("arst_running", running, 0);
        chk("arst_done", done, 0);
        chk("arst_cnt", cyc_cnt, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_drop", drop_cnt, 0);
        sb_q.delete();
        m_occ = 0;
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clr_stim();
        st_we[0] = 1'b1; st_addr[0] = 5'd9; st_data[0] = 32'h1234_5678;
        start_pulse();
        do_run(1'b0, '0, 0);

        // budget stop, x0 write ignored
        clr_stim();
        st_we[2] = 1'b1; st_addr[2] = 5'd5; st_data[2] = 32'd7;
        st_we[4] = 1'b1; st_addr[4] = 5'd0; st_data[4] = 32'd9;
        start_pulse();
        do_run(1'b0, '0, 0);
        chk("budget_stop_k", stop_k, MAXC - 1);

        // halt PC stop, stop-cycle write kept
        clr_stim();
        st_we[1] = 1'b1; st_addr[1] = 5'd2; st_data[1] = 32'hAA;
        st_we[4] = 1'b1; st_addr[4] = 5'd3; st_data[4] = 32'hABCD;
        start_pulse();
        do_run(1'b1, 32'h10, 0);
        chk("halt_stop_k", stop_k, 4);

        // overflow: six writes into a 4-entry FIFO nobody drains
        clr_stim();
        for (int k = 0; k < MAXC; k++) st_rdy[k] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            st_we[k] = 1'b1; st_addr[k] = 5'(k + 10); st_data[k] = 32'(100 + k);
        end
        start_pulse();
        do_run(1'b0, '0, 5);
        chk("ovf_drops_model", m_drops, 2);

        // full FIFO with push and pop in the same cycle
        clr_stim();
        for (int k = 0; k < 5; k++) begin
            st_we[k] = 1'b1; st_addr[k] = 5'(k + 20); st_data[k] = 32'(200 + k);
            st_rdy[k] = (k == 4);
        end
        start_pulse();
        do_run(1'b1, 32'h20, 0);
        chk("fullpp_drops_model", m_drops, 0);

        // start held through DONE must not retrigger
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; we = 1'b1; waddr = 5'd4; wdata = $urandom;
            model_step(1'b0, 0);
            @(negedge clk);
            chk("hold_done", done, 1);
            chk("hold_cnt", cyc_cnt, stop_k);
            tick();
        end

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            rnd_stim();
            start_pulse();
            do_run($urandom_range(0, 1), PC_W'(4 * $urandom_range(2, 40)),
                   $urandom_range(0, 3));
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
